// File: rtl/nn_layer_sequencer.sv
// Serial MLP inference controller: one shared accumulator walks every neuron of L1 -> L2 -> L3, then reports argmax.
// Optional NN_SEQ_PERF_EN adds perf_cycles_o / perf_sat_o counters for the last inference.
module nn_layer_sequencer #(
  parameter int INPUT_SIZE   = 784,
  parameter int HIDDEN1_SIZE = 64,
  parameter int HIDDEN2_SIZE = 32,
  parameter int OUTPUT_SIZE  = 10,
  parameter int DATA_W       = 16,
  parameter int FRAC         = 8,
  parameter int ACC_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [INPUT_SIZE-1:0] in_features_i,
  output logic [15:0]           w_addr_o,
  input  logic [DATA_W-1:0]     w_data_i,
  output logic [6:0]            b_addr_o,
  input  logic [DATA_W-1:0]     b_data_i,
  output logic [6:0]            act_rd_addr_o,
  input  logic [DATA_W-1:0]     act_rd_data_i,
  output logic                  act_wr_en_o,
  output logic [6:0]            act_wr_addr_o,
  output logic [DATA_W-1:0]     act_wr_data_o,
  output logic                  busy_o,
  output logic [3:0]            prediction_o,
  output logic                  done_o
`ifdef NN_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cycles_o,
  output logic [7:0]            perf_sat_o
`endif
);

  localparam int MAX_F = (INPUT_SIZE > HIDDEN1_SIZE)
                       ? ((INPUT_SIZE > HIDDEN2_SIZE) ? INPUT_SIZE : HIDDEN2_SIZE)
                       : ((HIDDEN1_SIZE > HIDDEN2_SIZE) ? HIDDEN1_SIZE : HIDDEN2_SIZE);
  localparam int KW      = $clog2(MAX_F + 1);
  localparam int W2_BASE = HIDDEN1_SIZE * INPUT_SIZE;
  localparam int W3_BASE = W2_BASE + HIDDEN2_SIZE * HIDDEN1_SIZE;
  localparam int B2_BASE = HIDDEN1_SIZE;
  localparam int B3_BASE = HIDDEN1_SIZE + HIDDEN2_SIZE;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
  localparam logic [1:0] L1 = 2'd1;
  localparam logic [1:0] L2 = 2'd2;
  localparam logic [1:0] L3 = 2'd3;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, WRITE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                layer_q, layer_d;
  logic [6:0]                n_q, n_d;
  logic [KW-1:0]             j_q, j_d;
  logic [INPUT_SIZE-1:0]     feat_q, feat_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   term_q, term_d;
  logic signed [DATA_W-1:0]  max_q, max_d;
  logic [3:0]                best_q, best_d;
  logic [3:0]                pred_q, pred_d;

  int                        fan_in, neurons, w_base, b_base, a_base;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   mac_term, sum;
  logic signed [DATA_W-1:0]  sat_val, relu_val;
  logic                      sat_hit, new_max;

  always_comb begin
    fan_in  = INPUT_SIZE;
    neurons = HIDDEN1_SIZE;
    w_base  = 0;
    b_base  = 0;
    a_base  = 0;
    case (layer_q)
      L2: begin
        fan_in = HIDDEN1_SIZE; neurons = HIDDEN2_SIZE; w_base = W2_BASE; b_base = B2_BASE; a_base = 0;
      end
      L3: begin
        fan_in = HIDDEN2_SIZE; neurons = OUTPUT_SIZE; w_base = W3_BASE; b_base = B3_BASE; a_base = HIDDEN1_SIZE;
      end
      default: ;
    endcase
  end

  // The term is registered one cycle before it is summed, so data arriving for k is added in the following cycle.
  always_comb begin
    prod = $signed(act_rd_data_i) * $signed(w_data_i);
    if (layer_q == L1) mac_term = feat_q[0] ? ACC_W'($signed(w_data_i)) : '0;
    else               mac_term = ACC_W'(prod) >>> FRAC;
    sum     = acc_q + term_q;
    sat_hit = (sum > SAT_MAX) || (sum < SAT_MIN);
    if (sum > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                    sat_val = sum[DATA_W-1:0];
    relu_val = sat_val[DATA_W-1] ? '0 : sat_val;
    new_max  = (n_q == '0) || (sat_val > max_q);
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    n_d     = n_q;
    j_d     = j_q;
    feat_d  = feat_q;
    acc_d   = acc_q;
    term_d  = term_q;
    max_d   = max_q;
    best_d  = best_q;
    pred_d  = pred_q;
    w_addr_o      = '0;
    b_addr_o      = '0;
    act_rd_addr_o = '0;
    act_wr_en_o   = 1'b0;
    act_wr_addr_o = '0;
    act_wr_data_o = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          feat_d  = in_features_i;
          layer_d = L1;
          n_d     = '0;
          j_d     = '0;
          state_d = BIAS;
        end
      end
      BIAS: begin
        b_addr_o = 7'(b_base + int'(n_q));
        w_addr_o = 16'(w_base + int'(n_q) * fan_in);
        if (layer_q != L1) act_rd_addr_o = 7'(a_base);
        j_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        w_addr_o = 16'(w_base + int'(n_q) * fan_in + int'(j_q) + 1);
        if (layer_q != L1) act_rd_addr_o = 7'(a_base + int'(j_q) + 1);
        term_d = mac_term;
        acc_d  = (j_q == '0) ? ACC_W'($signed(b_data_i)) : sum;
        // Rotating the image keeps the current feature at bit 0; a full fan-in restores it for the next neuron.
        if (layer_q == L1) feat_d = {feat_q[0], feat_q[INPUT_SIZE-1:1]};
        if (int'(j_q) == fan_in - 1) state_d = WRITE;
        else                         j_d = j_q + 1'b1;
      end
      WRITE: begin
        state_d = BIAS;
        if (layer_q != L3) begin
          act_wr_en_o   = 1'b1;
          act_wr_addr_o = 7'(((layer_q == L1) ? 0 : HIDDEN1_SIZE) + int'(n_q));
          act_wr_data_o = relu_val;
        end else if (new_max) begin
          max_d  = sat_val;
          best_d = n_q[3:0];
        end
        if (int'(n_q) == neurons - 1) begin
          n_d = '0;
          if (layer_q == L3) begin
            state_d = DONE;
            pred_d  = new_max ? n_q[3:0] : best_q;
          end else begin
            layer_d = layer_q + 2'd1;
          end
        end else begin
          n_d = n_q + 7'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      layer_q <= L1;
      n_q     <= '0;
      j_q     <= '0;
      feat_q  <= '0;
      acc_q   <= '0;
      term_q  <= '0;
      max_q   <= '0;
      best_q  <= '0;
      pred_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      n_q     <= n_d;
      j_q     <= j_d;
      feat_q  <= feat_d;
      acc_q   <= acc_d;
      term_q  <= term_d;
      max_q   <= max_d;
      best_q  <= best_d;
      pred_q  <= pred_d;
    end
  end

  assign busy_o       = (state_q == BIAS) || (state_q == MAC) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign prediction_o = pred_q;

`ifdef NN_SEQ_PERF_EN
  logic [31:0] cyc_q, cyc_d, perf_cycles_q, perf_cycles_d;
  logic [7:0]  sat_cnt_q, sat_cnt_d, perf_sat_q, perf_sat_d, sat_next;

  always_comb begin
    cyc_d         = cyc_q;
    sat_cnt_d     = sat_cnt_q;
    perf_cycles_d = perf_cycles_q;
    perf_sat_d    = perf_sat_q;
    sat_next      = (state_q == WRITE && sat_hit && sat_cnt_q != 8'hFF) ? sat_cnt_q + 8'd1 : sat_cnt_q;
    if (state_q == IDLE && start_i) begin
      cyc_d     = 32'd1;
      sat_cnt_d = '0;
    end else if (busy_o) begin
      cyc_d     = cyc_q + 32'd1;
      sat_cnt_d = sat_next;
    end
    if (state_q == WRITE && state_d == DONE) begin
      perf_cycles_d = cyc_q + 32'd1;
      perf_sat_d    = sat_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q         <= '0;
      sat_cnt_q     <= '0;
      perf_cycles_q <= '0;
      perf_sat_q    <= '0;
    end else begin
      cyc_q         <= cyc_d;
      sat_cnt_q     <= sat_cnt_d;
      perf_cycles_q <= perf_cycles_d;
      perf_sat_q    <= perf_sat_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_sat_o    = perf_sat_q;
`endif

endmodule
